// File: rtl/ccx_global_int_gen.sv
// rtl/ccx_global_int_gen.sv - CCX global reset / debug-init / scan-enable generator
// Optional build macro: CCX_GLOBAL_INT_GEN_SE_SYNC_EN (two-flop synchronizer on scan_en_in)
module ccx_global_int_gen #(
    parameter int HOLD_CYC    = 16,
    parameter int STAGGER_CYC = 4,
    parameter int CNT_W       = 8
) (
    input  logic rclk,
    input  logic rst,
    input  logic warm_rst_req,
    input  logic dbg_init_req,
    input  logic scan_en_in,
    output logic rst_l,
    output logic adbginit_l,
    output logic se,
    output logic busy,
    output logic seq_done
);

    localparam logic [1:0] ST_ASSERT  = 2'd0;
    localparam logic [1:0] ST_STAGGER = 2'd1;
    localparam logic [1:0] ST_RUN     = 2'd2;
    localparam logic [1:0] ST_DBG     = 2'd3;

    // Terminal counts: compared before increment so the counter never wraps
    localparam logic [CNT_W-1:0] HOLD_TC    = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] STAGGER_TC = CNT_W'(STAGGER_CYC - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rst_l_q, rst_l_d;
    logic             adbginit_l_q, adbginit_l_d;
    logic             seq_done_q, seq_done_d;

    // Next-state and counter; warm reset has priority over debug-init
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ASSERT: begin
                if (cnt_q == HOLD_TC) state_d = ST_STAGGER;
            end
            ST_STAGGER: begin
                if (cnt_q == STAGGER_TC) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (warm_rst_req)      state_d = ST_ASSERT;
                else if (dbg_init_req) state_d = ST_DBG;
            end
            ST_DBG: begin
                if (warm_rst_req)          state_d = ST_ASSERT;
                else if (cnt_q == HOLD_TC) state_d = ST_RUN;
            end
            default: state_d = ST_ASSERT;
        endcase

        // Counter idles in RUN, clears on any state change
        if (state_d != state_q)  cnt_d = '0;
        else if (state_q == ST_RUN) cnt_d = cnt_q;
        else                     cnt_d = cnt_q + CNT_W'(1);
    end

    // Output registers decoded from the next state so they change with the state
    always_comb begin
        rst_l_d      = (state_d == ST_RUN) || (state_d == ST_DBG);
        adbginit_l_d = (state_d == ST_STAGGER) || (state_d == ST_RUN);
        seq_done_d   = (state_d == ST_RUN) && (state_q != ST_RUN);
    end

    // State machine and output flops
    always_ff @(posedge rclk) begin
        if (rst) begin
            state_q      <= ST_ASSERT;
            cnt_q        <= '0;
            rst_l_q      <= 1'b0;
            adbginit_l_q <= 1'b0;
            seq_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rst_l_q      <= rst_l_d;
            adbginit_l_q <= adbginit_l_d;
            seq_done_q   <= seq_done_d;
        end
    end

`ifdef CCX_GLOBAL_INT_GEN_SE_SYNC_EN
    logic se_meta_q, se_meta_d;
    logic se_q, se_d;

    // Two-flop synchronizer for the asynchronous test-controller scan enable
    always_comb begin
        se_meta_d = scan_en_in;
        se_d      = se_meta_q;
    end

    // Synchronizer flops
    always_ff @(posedge rclk) begin
        if (rst) begin
            se_meta_q <= 1'b0;
            se_q      <= 1'b0;
        end else begin
            se_meta_q <= se_meta_d;
            se_q      <= se_d;
        end
    end
`else
    logic se_q, se_d;

    // Single register on the scan enable request
    always_comb begin
        se_d = scan_en_in;
    end

    // Scan enable flop
    always_ff @(posedge rclk) begin
        if (rst) se_q <= 1'b0;
        else     se_q <= se_d;
    end
`endif

    assign rst_l      = rst_l_q;
    assign adbginit_l = adbginit_l_q;
    assign seq_done   = seq_done_q;
    assign se         = se_q;
    assign busy       = (state_q != ST_RUN);

endmodule

// File: doc/ccx_global_int_gen.md
# ccx_global_int_gen

Source of the global CCX control signals: generates the active-low core reset (`rst_l`), active-low debug-init (`adbginit_l`) and scan enable (`se`) that the global buffer tree fans out to the crossbar. A small state machine runs the power-on and warm-reset sequence with a staggered release: `adbginit_l` deasserts first, then `rst_l`. It also runs a debug-init-only pulse and registers the scan-enable request. The block sits at the clock/reset control unit boundary, upstream of the CCX global buffers.

## Interface
- `HOLD_CYC`, default 16: cycles both `rst_l` and `adbginit_l` are held low; also the length of the debug-init pulse.
- `STAGGER_CYC`, default 4: cycles between the release of `adbginit_l` and the release of `rst_l`.
- `CNT_W`, default 8: width of the sequence counter. `HOLD_CYC` and `STAGGER_CYC` must each lie in 1..2^CNT_W-1.

Ports:
- `rclk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `warm_rst_req` input 1: single-cycle warm-reset request.
- `dbg_init_req` input 1: single-cycle debug-init request.
- `scan_en_in` input 1: scan-enable request from the test controller.
- `rst_l` output 1: registered core reset, active low.
- `adbginit_l` output 1: registered debug init, active low.
- `se` output 1: registered scan enable.
- `busy` output 1: high in any state other than RUN.
- `seq_done` output 1: one-cycle pulse on every entry to RUN.

## Operation
- States: ASSERT, STAGGER, RUN, DBG. A counter of width `CNT_W` counts cycles within the current state and clears on every state change.
- **ASSERT**
  - Outputs: `rst_l`=0, `adbginit_l`=0.
  - Stays for `HOLD_CYC` cycles, then moves to STAGGER.
- **STAGGER**
  - Outputs: `adbginit_l`=1, `rst_l`=0.
  - Stays for `STAGGER_CYC` cycles, then moves to RUN.
- **RUN**
  - Outputs: both high.
  - `seq_done`=1 on the first RUN cycle only.
  - `warm_rst_req`=1 moves to ASSERT.
  - `dbg_init_req`=1 moves to DBG.
  - If both requests are high in the same cycle, the warm reset wins and the debug request is dropped.
- **DBG**
  - Outputs: `rst_l`=1, `adbginit_l`=0.
  - Stays for `HOLD_CYC` cycles, then returns to RUN; `seq_done` pulses on that return.
  - `warm_rst_req` during DBG aborts the pulse and moves to ASSERT on the next edge.
  - `dbg_init_req` during DBG is ignored and does not extend the pulse.
- In ASSERT and STAGGER, both request inputs are ignored and no request is queued.
- `se` is independent of the state machine: it is a registered copy of `scan_en_in`.
- `busy` is a combinational decode of state (state != RUN).

## Timing
- Reset values, held while `rst`=1:
  - `rst_l`=0, `adbginit_l`=0, `se`=0, `busy`=1, `seq_done`=0.
  - State=ASSERT, counter=0.
- After reset release, let edge 1 be the first rising edge at which `rst` is sampled low:
  - `adbginit_l` goes high after edge `HOLD_CYC`.
  - `rst_l` goes high after edge `HOLD_CYC`+`STAGGER_CYC`.
  - `seq_done` and `busy`=0 appear in that same cycle.
- A request sampled at edge n in RUN changes outputs after edge n (one-cycle latency):
  - A warm reset produces `rst_l`=`adbginit_l`=0 from edge n; the full sequence then repeats with the same counts as after reset.
  - A debug-init produces `adbginit_l`=0 for exactly `HOLD_CYC` cycles.
- `rst` asserted mid-sequence forces reset values at the next edge. There is no partial release, and the sequence restarts from the first ASSERT cycle.
- `se` latency from `scan_en_in`: 1 cycle by default, 2 cycles with the Configuration macro defined.
- The counter never wraps: the terminal-count compare happens before increment, and the parameter range above guarantees the compare is reachable.

## Configuration
- Macro: `CCX_GLOBAL_INT_GEN_SE_SYNC_EN`.
- Defined: `scan_en_in` passes through a two-flop synchronizer before `se`. Latency is 2 cycles and both flops reset to 0.
- Undefined: a single register, 1-cycle latency, reset to 0.
- `rst_l` and `adbginit_l` behaviour is identical in both builds.

## Test plan
- Power-on, defaults (`HOLD_CYC`=16, `STAGGER_CYC`=4), `rst` high 3 cycles then low -> `adbginit_l` rises after edge 16, `rst_l` rises after edge 20, `seq_done` is high for 1 cycle and `busy` drops at edge 20.
- In RUN, pulse `dbg_init_req` -> `adbginit_l` low for exactly 16 cycles with `rst_l` held at 1, then `seq_done` pulses once.
- In RUN, `warm_rst_req` and `dbg_init_req` high in the same cycle -> full warm sequence (16 cycles both low, 4 cycles stagger) and no DBG pulse afterwards.
- `warm_rst_req` at DBG cycle 5 -> ASSERT at the next edge, both outputs low, full 16+4 sequence follows; `dbg_init_req` pulsed during ASSERT has no effect.
- `rst` reasserted at STAGGER cycle 2 -> next edge `adbginit_l`=0, `rst_l`=0, `busy`=1; after release the full 16+4 sequence runs again.
- Toggle `scan_en_in` 0->1->0 with 3-cycle spacing -> `se` follows with 1-cycle delay, or 2-cycle delay with `CCX_GLOBAL_INT_GEN_SE_SYNC_EN`; `se`=0 during reset.
